// File: rtl/avalon_pio_out_seq.sv
// Avalon-MM output port with direct write, atomic set/clear and a timed bit-inversion pulse engine.
// Define PIO_PULSE_IRQ_EN to add a sticky pulse-done flag, IRQ enable register and irq output.
module avalon_pio_out_seq #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter int               PULSE_CNT_W   = 16,
  parameter int               PULSE_DEFAULT = 100
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             busy
`ifdef PIO_PULSE_IRQ_EN
  ,
  output logic             irq
`endif
);

  typedef enum logic {IDLE, PULSE} state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic [WIDTH-1:0]       mask_q, mask_d;
  logic [PULSE_CNT_W-1:0] pulseLen_q, pulseLen_d;
  logic [PULSE_CNT_W-1:0] count_q, count_d;
  logic                   wr;
  logic [WIDTH-1:0]       wrBits;
  logic                   unused_ok;

  assign wr        = chipselect & ~write_n;
  assign wrBits    = writedata[WIDTH-1:0];
  assign unused_ok = ^writedata;

  always_comb begin
    data_d     = data_q;
    pulseLen_d = pulseLen_q;
    mask_d     = mask_q;
    count_d    = count_q;
    state_d    = state_q;
    if (wr) begin
      case (address)
        3'd0:    data_d = wrBits;
        3'd1:    data_d = data_q | wrBits;
        3'd2:    data_d = data_q & ~wrBits;
        3'd3:    pulseLen_d = writedata[PULSE_CNT_W-1:0];
        default: ;
      endcase
    end
    // The running count is private to the engine, so PULSE_LEN writes mid-pulse only affect the next pulse.
    case (state_q)
      IDLE: begin
        if (wr && address == 3'd4 && wrBits != '0 && pulseLen_q != '0) begin
          state_d = PULSE;
          count_d = pulseLen_q;
          mask_d  = wrBits;
        end
      end
      PULSE: begin
        count_d = count_q - PULSE_CNT_W'(1);
        if (count_q == PULSE_CNT_W'(1)) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      data_q     <= RESET_VALUE;
      mask_q     <= '0;
      pulseLen_q <= PULSE_CNT_W'(PULSE_DEFAULT);
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      pulseLen_q <= pulseLen_d;
      count_q    <= count_d;
    end
  end

  assign busy     = (state_q == PULSE);
  assign out_port = data_q ^ (busy ? mask_q : '0);

`ifdef PIO_PULSE_IRQ_EN
  logic doneQ_unusedGuard;
  logic done_q, done_d;
  logic irqEn_q, irqEn_d;
  logic pulseEnd;

  assign doneQ_unusedGuard = 1'b0;
  assign pulseEnd = busy && (count_q == PULSE_CNT_W'(1));

  // Set is applied after clear so a completion in the same cycle as a clear write is not lost.
  always_comb begin
    done_d  = done_q;
    irqEn_d = irqEn_q;
    if (wr && address == 3'd5 && writedata[1]) done_d = 1'b0;
    if (pulseEnd) done_d = 1'b1;
    if (wr && address == 3'd6) irqEn_d = writedata[0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q  <= 1'b0;
      irqEn_q <= 1'b0;
    end else begin
      done_q  <= done_d;
      irqEn_q <= irqEn_d;
    end
  end

  assign irq = done_q & irqEn_q;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata[WIDTH-1:0]       = data_q;
      3'd3: readdata[PULSE_CNT_W-1:0] = pulseLen_q;
      3'd4: readdata[WIDTH-1:0]       = mask_q;
      3'd5: begin
        readdata[0] = busy;
`ifdef PIO_PULSE_IRQ_EN
        readdata[1] = done_q;
`endif
      end
`ifdef PIO_PULSE_IRQ_EN
      3'd6: readdata[0] = irqEn_q;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_avalon_pio_out_seq.sv
// Scoreboard bench for avalon_pio_out_seq: stimulus queues expected values per cycle, a negedge monitor compares.
`timescale 1ns/1ps
module tb_avalon_pio_out_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        busy;
`ifdef PIO_PULSE_IRQ_EN
  logic        irq;
`endif

  localparam int SIG_OUT = 0, SIG_BUSY = 1, SIG_READ = 2, SIG_IRQ = 3;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  avalon_pio_out_seq #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .PULSE_CNT_W(16), .PULSE_DEFAULT(100)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .busy(busy)
`ifdef PIO_PULSE_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation due in the current cycle and compares it with the live DUT output.
  exp_t        mon;
  logic [31:0] act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon = sb.pop_front();
      case (mon.sig)
        SIG_OUT:  act = {24'b0, out_port};
        SIG_BUSY: act = {31'b0, busy};
        SIG_READ: act = readdata;
`ifdef PIO_PULSE_IRQ_EN
        SIG_IRQ:  act = {31'b0, irq};
`endif
        default:  act = 32'hDEAD_BEEF;
      endcase
      checks++;
      if (mon.cyc != cyc || act !== mon.exp) begin
        errors++;
        $display("[TB] FAIL %s: got %h, expected %h (due cycle %0d, now %0d)",
                 mon.name, act, mon.exp, mon.cyc, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic checkOutput(input int sig, input logic [31:0] exp, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.sig  = sig;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic readReg(input logic [2:0] a, input logic [31:0] exp, input string name);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    checkOutput(SIG_READ, exp, name);
    tick();
    chipselect = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    tick();
    checkOutput(SIG_OUT, 32'hA5, "reset out_port");
    checkOutput(SIG_BUSY, 32'h0, "reset busy");
    tick();
    tick();
    reset_n = 1'b1;
    checkOutput(SIG_OUT, 32'hA5, "post-reset out_port");
    checkOutput(SIG_BUSY, 32'h0, "post-reset busy");
    readReg(3'd3, 32'd100, "reset PULSE_LEN");
    readReg(3'd5, 32'd0, "reset STATUS");

    // Direct write (upper writedata bits ignored), set, clear.
    applyStimulus(3'd0, 32'hABCD_120F);
    checkOutput(SIG_OUT, 32'h0F, "DATA write");
    applyStimulus(3'd1, 32'hFFFF_FF30 & 32'h0000_0030);
    checkOutput(SIG_OUT, 32'h3F, "SET write");
    applyStimulus(3'd2, 32'h0000_0005);
    checkOutput(SIG_OUT, 32'h3A, "CLR write");
    readReg(3'd0, 32'h3A, "DATA read");
    readReg(3'd1, 32'h0, "SET read");
    readReg(3'd2, 32'h0, "CLR read");
    readReg(3'd7, 32'h0, "addr7 read");

    // 5-cycle pulse on bit0.
    applyStimulus(3'd3, 32'd5);
    applyStimulus(3'd0, 32'hFF);
    applyStimulus(3'd4, 32'h01);
    for (int i = 0; i < 5; i++) begin
      address = 3'd5;
      checkOutput(SIG_OUT, 32'hFE, "pulse5 out");
      checkOutput(SIG_BUSY, 32'h1, "pulse5 busy");
      checkOutput(SIG_READ, 32'h1, "pulse5 STATUS");
      tick();
    end
    checkOutput(SIG_OUT, 32'hFF, "pulse5 restored");
    checkOutput(SIG_BUSY, 32'h0, "pulse5 busy end");
    readReg(3'd4, 32'h01, "mask read");
    readReg(3'd3, 32'd5, "PULSE_LEN read");

    // 10-cycle pulse with ignored re-trigger, SET and PULSE_LEN write mid-pulse.
    applyStimulus(3'd0, 32'h00);
    applyStimulus(3'd3, 32'd10);
    applyStimulus(3'd4, 32'h01);
    checkOutput(SIG_OUT, 32'h01, "pulse10 c0 out");
    checkOutput(SIG_BUSY, 32'h1, "pulse10 c0 busy");
    applyStimulus(3'd4, 32'h02);
    checkOutput(SIG_OUT, 32'h01, "retrigger ignored");
    checkOutput(SIG_BUSY, 32'h1, "pulse10 c1 busy");
    applyStimulus(3'd1, 32'h80);
    checkOutput(SIG_OUT, 32'h81, "SET during pulse");
    checkOutput(SIG_BUSY, 32'h1, "pulse10 c2 busy");
    applyStimulus(3'd3, 32'd3);
    for (int i = 3; i < 10; i++) begin
      checkOutput(SIG_OUT, 32'h81, "pulse10 out");
      checkOutput(SIG_BUSY, 32'h1, "pulse10 busy");
      tick();
    end
    checkOutput(SIG_OUT, 32'h80, "pulse10 restored");
    checkOutput(SIG_BUSY, 32'h0, "pulse10 busy end");
    readReg(3'd3, 32'd3, "PULSE_LEN updated mid-pulse");
    readReg(3'd4, 32'h01, "mask kept after retrigger");

    // Ignored starts: zero length, zero mask.
    applyStimulus(3'd3, 32'd0);
    applyStimulus(3'd4, 32'h01);
    checkOutput(SIG_BUSY, 32'h0, "zero len busy");
    checkOutput(SIG_OUT, 32'h80, "zero len out");
    tick();
    checkOutput(SIG_BUSY, 32'h0, "zero len busy later");
    readReg(3'd4, 32'h01, "zero len mask unchanged");
    applyStimulus(3'd3, 32'd5);
    applyStimulus(3'd4, 32'h00);
    checkOutput(SIG_BUSY, 32'h0, "zero mask busy");
    checkOutput(SIG_OUT, 32'h80, "zero mask out");
    tick();
    checkOutput(SIG_BUSY, 32'h0, "zero mask busy later");
    readReg(3'd4, 32'h01, "zero mask mask unchanged");

    // Single-cycle pulse.
    applyStimulus(3'd3, 32'd1);
    applyStimulus(3'd4, 32'h01);
    checkOutput(SIG_OUT, 32'h81, "len1 out");
    checkOutput(SIG_BUSY, 32'h1, "len1 busy");
    tick();
    checkOutput(SIG_OUT, 32'h80, "len1 restored");
    checkOutput(SIG_BUSY, 32'h0, "len1 busy end");

    // Maximum length pulse, no wrap.
    applyStimulus(3'd3, 32'h0001_FFFF);
    readReg(3'd3, 32'h0000_FFFF, "max PULSE_LEN read");
    applyStimulus(3'd4, 32'h80);
    checkOutput(SIG_OUT, 32'h00, "max first out");
    checkOutput(SIG_BUSY, 32'h1, "max first busy");
    repeat (65534) tick();
    checkOutput(SIG_OUT, 32'h00, "max last out");
    checkOutput(SIG_BUSY, 32'h1, "max last busy");
    tick();
    checkOutput(SIG_OUT, 32'h80, "max restored");
    checkOutput(SIG_BUSY, 32'h0, "max busy end");

`ifdef PIO_PULSE_IRQ_EN
    applyStimulus(3'd5, 32'h2);
    readReg(3'd5, 32'h0, "done cleared");
    applyStimulus(3'd6, 32'h1);
    readReg(3'd6, 32'h1, "IRQ_EN read");
    checkOutput(SIG_IRQ, 32'h0, "irq idle");
    applyStimulus(3'd3, 32'd3);
    applyStimulus(3'd4, 32'h01);
    for (int i = 0; i < 3; i++) begin
      checkOutput(SIG_BUSY, 32'h1, "irq pulse busy");
      checkOutput(SIG_IRQ, 32'h0, "irq during pulse");
      tick();
    end
    checkOutput(SIG_BUSY, 32'h0, "irq pulse busy end");
    checkOutput(SIG_IRQ, 32'h1, "irq after pulse");
    readReg(3'd5, 32'h2, "STATUS done");
    checkOutput(SIG_IRQ, 32'h1, "irq sticky");
    applyStimulus(3'd5, 32'h2);
    checkOutput(SIG_IRQ, 32'h0, "irq cleared");
    applyStimulus(3'd4, 32'h01);
    tick();
    tick();
    checkOutput(SIG_BUSY, 32'h1, "setwins last busy");
    applyStimulus(3'd5, 32'h2);
    checkOutput(SIG_BUSY, 32'h0, "setwins busy end");
    checkOutput(SIG_IRQ, 32'h1, "set wins over clear");
`else
    applyStimulus(3'd6, 32'h1);
    readReg(3'd6, 32'h0, "addr6 reads 0");
    readReg(3'd5, 32'h0, "STATUS no done bit");
`endif

    // Reset mid-pulse.
    applyStimulus(3'd3, 32'd8);
    applyStimulus(3'd4, 32'h01);
    checkOutput(SIG_OUT, 32'h81, "prereset out");
    checkOutput(SIG_BUSY, 32'h1, "prereset busy");
    tick();
    reset_n = 1'b0;
    checkOutput(SIG_OUT, 32'hA5, "midreset out");
    checkOutput(SIG_BUSY, 32'h0, "midreset busy");
`ifdef PIO_PULSE_IRQ_EN
    checkOutput(SIG_IRQ, 32'h0, "midreset irq");
`endif
    tick();
    reset_n = 1'b1;
    checkOutput(SIG_OUT, 32'hA5, "after reset out");
    checkOutput(SIG_BUSY, 32'h0, "after reset busy");
    readReg(3'd3, 32'd100, "after reset PULSE_LEN");
    readReg(3'd4, 32'h0, "after reset mask");
`ifdef PIO_PULSE_IRQ_EN
    readReg(3'd6, 32'h0, "after reset IRQ_EN");
`endif

    tick();
    tick();
    if (sb.size() != 0) begin
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
      errors += sb.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
